// File: rtl/local_code_gen.sv
// local_code_gen
//   Local replica generator for the B1 correlation channel. A code NCO steps a
//   pair of 11-stage Gold-code registers (G1, G2); the chip value, optionally
//   XORed with a half-chip BOC(1,1) square subcarrier, is emitted once per
//   sample strobe together with start/end-of-period markers for the
//   correlator accumulator. One code period (CODE_LEN chips) spans sop..eop.
//
// Ports
//   rx_clk, rx_rst_n    sample clock, asynchronous active-low reset
//   cfg_start/cfg_stop  restart at chip 0 (config latched) / halt to IDLE
//   cfg_fcw             code NCO frequency control word
//   cfg_tap1/cfg_tap2   G2 phase-select taps, 1..11 (0 or >11 act as 11)
//   cfg_boc_en          enable half-chip subcarrier
//   sample_en           one code sample per strobe
//   tx_loc_boc          replica sign (1 = +1), 1 cycle after the strobe
//   tx_valid/sop/eop    sample strobe and period markers, LOC_LEAD+1 cycles after
//   tx_chip_cnt         current chip index
//   tx_busy             high in LOAD or RUN
module local_code_gen #(
    parameter int unsigned NCO_WIDTH = 32,
    parameter int unsigned CODE_LEN  = 2046,
    parameter int unsigned LOC_LEAD  = 1
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst_n,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic [NCO_WIDTH-1:0] cfg_fcw,
    input  logic [3:0]           cfg_tap1,
    input  logic [3:0]           cfg_tap2,
    input  logic                 cfg_boc_en,
    input  logic                 sample_en,
    output logic                 tx_loc_boc,
    output logic                 tx_prn_sop,
    output logic                 tx_prn_eop,
    output logic                 tx_valid,
    output logic [10:0]          tx_chip_cnt,
    output logic                 tx_busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

    // Register bit b holds shift stage b+1; stage 11 (bit 10) is the G1 output.
    localparam logic [10:0] G_INIT    = 11'b01010101010;
    localparam logic [10:0] LAST_CHIP = 11'(CODE_LEN - 1);

    state_t               state, state_nxt;
    logic [NCO_WIDTH-1:0] fcw_q, phase, phase_sum;
    logic [3:0]           sel1_q, sel2_q;
    logic                 boc_q;
    logic [10:0]          g1, g2, chip_cnt;
    logic                 sop_pend;
    logic                 emit, carry, wrap, code;
    logic                 v1, s1, e1;

    // Tap number 1..11 to zero-based stage index; out-of-range taps select stage 11.
    function automatic logic [3:0] tap_sel(input logic [3:0] t);
        return (t == 4'd0 || t > 4'd11) ? 4'd10 : t - 4'd1;
    endfunction

    // G1: 1+x+x^7+x^8+x^9+x^10+x^11
    function automatic logic [10:0] lfsr_g1(input logic [10:0] g);
        return {g[9:0], g[0] ^ g[6] ^ g[7] ^ g[8] ^ g[9] ^ g[10]};
    endfunction

    // G2: 1+x+x^2+x^3+x^4+x^5+x^8+x^9+x^11
    function automatic logic [10:0] lfsr_g2(input logic [10:0] g);
        return {g[9:0], g[0] ^ g[1] ^ g[2] ^ g[3] ^ g[4] ^ g[7] ^ g[8] ^ g[10]};
    endfunction

    // State register
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state: stop wins over start
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_stop) state_nxt = IDLE;
                     else if (cfg_start) state_nxt = LOAD;
            LOAD:    if (cfg_stop) state_nxt = IDLE;
                     else if (cfg_start) state_nxt = LOAD;
                     else state_nxt = RUN;
            RUN:     if (cfg_stop) state_nxt = IDLE;
                     else if (cfg_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // State-derived outputs; a strobe coinciding with stop/start is dropped
    always_comb begin
        tx_busy     = (state != IDLE);
        emit        = (state == RUN) && sample_en && !cfg_stop && !cfg_start;
        tx_chip_cnt = chip_cnt;
    end

    always_comb begin
        {carry, phase_sum} = {1'b0, phase} + {1'b0, fcw_q};
        wrap = carry && (chip_cnt == LAST_CHIP);
        code = g1[10] ^ g2[sel1_q] ^ g2[sel2_q];
    end

    // NCO, code registers and chip counter
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            fcw_q    <= '0;
            sel1_q   <= '0;
            sel2_q   <= '0;
            boc_q    <= 1'b0;
            phase    <= '0;
            chip_cnt <= '0;
            g1       <= G_INIT;
            g2       <= G_INIT;
            sop_pend <= 1'b0;
        end else if (state == LOAD) begin
            fcw_q    <= cfg_fcw;
            sel1_q   <= tap_sel(cfg_tap1);
            sel2_q   <= tap_sel(cfg_tap2);
            boc_q    <= cfg_boc_en;
            phase    <= '0;
            chip_cnt <= '0;
            g1       <= G_INIT;
            g2       <= G_INIT;
            sop_pend <= 1'b1;
        end else if (emit) begin
            phase    <= phase_sum;
            sop_pend <= wrap;
            if (wrap) begin
                chip_cnt <= '0;
                g1       <= G_INIT;
                g2       <= G_INIT;
            end else if (carry) begin
                chip_cnt <= chip_cnt + 11'd1;
                g1       <= lfsr_g1(g1);
                g2       <= lfsr_g2(g2);
            end
        end
    end

    // First output stage; the sign holds between strobes and clears on entry to IDLE
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            tx_loc_boc <= 1'b0;
            v1         <= 1'b0;
            s1         <= 1'b0;
            e1         <= 1'b0;
        end else begin
            v1 <= emit;
            s1 <= emit && sop_pend;
            e1 <= emit && wrap;
            if (emit)                   tx_loc_boc <= ~(code ^ (boc_q & phase[NCO_WIDTH-1]));
            else if (state_nxt == IDLE) tx_loc_boc <= 1'b0;
        end
    end

    if (LOC_LEAD != 0) begin : g_lead
        logic v2, s2, e2;
        logic flush;

        // Pulses still in flight when a period is cut short must not reach the accumulator
        always_comb flush = (state != RUN) || (state_nxt != RUN);

        always_ff @(posedge rx_clk or negedge rx_rst_n) begin
            if (!rx_rst_n) begin
                v2 <= 1'b0;
                s2 <= 1'b0;
                e2 <= 1'b0;
            end else if (flush) begin
                v2 <= 1'b0;
                s2 <= 1'b0;
                e2 <= 1'b0;
            end else begin
                v2 <= v1;
                s2 <= s1;
                e2 <= e1;
            end
        end

        assign tx_valid   = v2;
        assign tx_prn_sop = s2;
        assign tx_prn_eop = e2;
    end else begin : g_nolead
        assign tx_valid   = v1;
        assign tx_prn_sop = s1;
        assign tx_prn_eop = e1;
    end

endmodule

// File: tb/tb_local_code_gen.sv
// tb_local_code_gen
//   Drives local_code_gen with directed and randomized runs. Expected samples
//   come from a closed-form reference: sample n lies at NCO position n*fcw, so
//   the chip is floor(n*fcw/2^32) mod CODE_LEN and the subcarrier is bit 31 of
//   n*fcw; chip values come from a precomputed Gold-code table.
module tb_local_code_gen;

    localparam int CODE_LEN = 2046;

    logic        rx_clk = 1'b0;
    logic        rx_rst_n;
    logic        cfg_start, cfg_stop, cfg_boc_en, sample_en;
    logic [31:0] cfg_fcw;
    logic [3:0]  cfg_tap1, cfg_tap2;
    logic        tx_loc_boc, tx_prn_sop, tx_prn_eop, tx_valid, tx_busy;
    logic [10:0] tx_chip_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          code_tbl [CODE_LEN];
    longint      m_n, m_fcw;
    bit          m_boc;
    bit          m_run = 1'b0;
    logic [2:0]  exp_q [$];
    logic [2:0]  mon_exp;
    logic        prev_loc = 1'b0;

    local_code_gen #(
        .NCO_WIDTH (32),
        .CODE_LEN  (CODE_LEN),
        .LOC_LEAD  (1)
    ) dut (
        .rx_clk      (rx_clk),
        .rx_rst_n    (rx_rst_n),
        .cfg_start   (cfg_start),
        .cfg_stop    (cfg_stop),
        .cfg_fcw     (cfg_fcw),
        .cfg_tap1    (cfg_tap1),
        .cfg_tap2    (cfg_tap2),
        .cfg_boc_en  (cfg_boc_en),
        .sample_en   (sample_en),
        .tx_loc_boc  (tx_loc_boc),
        .tx_prn_sop  (tx_prn_sop),
        .tx_prn_eop  (tx_prn_eop),
        .tx_valid    (tx_valid),
        .tx_chip_cnt (tx_chip_cnt),
        .tx_busy     (tx_busy)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Gold code for one period: stage k of each register held in s[k], output stage 11
    function automatic void build_table(input int t1, input int t2);
        int s1 [12];
        int s2 [12];
        int f1, f2;
        if (t1 < 1 || t1 > 11) t1 = 11;
        if (t2 < 1 || t2 > 11) t2 = 11;
        for (int k = 1; k <= 11; k++) begin
            s1[k] = (k % 2 == 0) ? 1 : 0;
            s2[k] = s1[k];
        end
        for (int i = 0; i < CODE_LEN; i++) begin
            code_tbl[i] = bit'(s1[11] ^ s2[t1] ^ s2[t2]);
            f1 = s1[1] ^ s1[7] ^ s1[8] ^ s1[9] ^ s1[10] ^ s1[11];
            f2 = s2[1] ^ s2[2] ^ s2[3] ^ s2[4] ^ s2[5] ^ s2[8] ^ s2[9] ^ s2[11];
            for (int k = 11; k >= 2; k--) begin
                s1[k] = s1[k-1];
                s2[k] = s2[k-1];
            end
            s1[1] = f1;
            s2[1] = f2;
        end
    endfunction

    // {tx_loc_boc, sop, eop} for the n-th strobe since the last start
    function automatic logic [2:0] model_sample(input longint n);
        longint a, a1, ap, chip;
        bit     sub, sop, eop;
        a    = (n * m_fcw) >> 32;
        a1   = ((n + 1) * m_fcw) >> 32;
        ap   = (n > 0) ? (((n - 1) * m_fcw) >> 32) : -1;
        chip = a % CODE_LEN;
        sub  = bit'(((n * m_fcw) >> 31) & 1);
        sop  = (chip == 0) && (a != ap);
        eop  = (a1 != a) && (a1 % CODE_LEN == 0);
        return {~(code_tbl[int'(chip)] ^ (m_boc & sub)), sop, eop};
    endfunction

    function automatic logic [31:0] model_chip();
        return 32'(((m_n * m_fcw) >> 32) % CODE_LEN);
    endfunction

    // Sign is checked one cycle before its valid (LOC_LEAD = 1)
    always @(negedge rx_clk) begin
        if (tx_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(tx_valid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sample", 32'({prev_loc, tx_prn_sop, tx_prn_eop}), 32'(mon_exp));
            end
        end
        prev_loc = tx_loc_boc;
    end

    task automatic step(input bit en);
        @(negedge rx_clk);
        sample_en = en;
        if (en && m_run) begin
            exp_q.push_back(model_sample(m_n));
            m_n++;
        end
    endtask

    task automatic start_run(input logic [31:0] fcw, input logic [3:0] t1,
                             input logic [3:0] t2, input bit boc);
        @(negedge rx_clk);
        cfg_fcw = fcw; cfg_tap1 = t1; cfg_tap2 = t2; cfg_boc_en = boc;
        cfg_start = 1'b1; sample_en = 1'b0;
        #1;
        exp_q.delete();
        build_table(int'(t1), int'(t2));
        m_fcw = longint'(fcw); m_boc = boc; m_n = 0; m_run = 1'b1;
        @(negedge rx_clk);
        cfg_start = 1'b0;
    endtask

    task automatic stop_run();
        @(negedge rx_clk);
        cfg_stop = 1'b1; sample_en = 1'b0;
        #1;
        exp_q.delete();
        m_run = 1'b0;
        @(negedge rx_clk);
        cfg_stop = 1'b0;
        chk("busy_after_stop", 32'(tx_busy), 32'd0);
        chk("loc_after_stop", 32'(tx_loc_boc), 32'd0);
    endtask

    task automatic drain();
        repeat (4) step(1'b0);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rx_rst_n = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_boc_en = 1'b0;
        sample_en = 1'b0; cfg_fcw = '0; cfg_tap1 = 4'd1; cfg_tap2 = 4'd3;
        repeat (3) @(negedge rx_clk);
        chk("reset_flags", 32'({tx_valid, tx_prn_sop, tx_prn_eop, tx_loc_boc, tx_busy}), 32'd0);
        chk("reset_chip", 32'(tx_chip_cnt), 32'd0);
        @(negedge rx_clk);
        rx_rst_n = 1'b1;
        repeat (5) step(1'b1);
        chk("idle_busy", 32'(tx_busy), 32'd0);

        // Two periods at half a chip per sample
        start_run(32'h8000_0000, 4'd1, 4'd3, 1'b0);
        chk("busy_run", 32'(tx_busy), 32'd1);
        repeat (2 * 4092 + 6) step(1'b1);
        drain();
        stop_run();

        // Quarter chip per sample with subcarrier, random taps (out-of-range included)
        start_run(32'h4000_0000, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        repeat (8184 + 10) step(1'b1);
        drain();
        stop_run();

        // Alternating strobes: chips advance every two strobes only
        start_run(32'h8000_0000, 4'd5, 4'd9, 1'b0);
        for (int i = 0; i < 4092 + 4; i++) begin
            step(1'b1);
            step(1'b0);
        end
        chk("chip_gapped", 32'(tx_chip_cnt), model_chip());
        drain();
        stop_run();

        // Stop at chip 1000, then start and stop together
        start_run(32'h8000_0000, 4'd2, 4'd6, 1'($urandom_range(0, 1)));
        repeat (2000) step(1'b1);
        step(1'b0);
        chk("chip_at_stop", 32'(tx_chip_cnt), model_chip());
        stop_run();
        repeat (5) step(1'b1);
        @(negedge rx_clk);
        cfg_start = 1'b1; cfg_stop = 1'b1;
        @(negedge rx_clk);
        cfg_start = 1'b0; cfg_stop = 1'b0;
        chk("start_stop_busy", 32'(tx_busy), 32'd0);
        repeat (3) step(1'b1);
        chk("start_stop_busy2", 32'(tx_busy), 32'd0);

        // Restart mid-period at chip 500
        start_run(32'h8000_0000, 4'd4, 4'd8, 1'b0);
        repeat (1000) step(1'b1);
        start_run(32'h8000_0000, 4'd7, 4'd11, 1'b1);
        repeat (1500) step(1'b1);
        step(1'b0);
        chk("chip_after_restart", 32'(tx_chip_cnt), model_chip());
        drain();
        stop_run();

        // Frozen NCO
        start_run(32'h0, 4'd3, 4'd10, 1'b1);
        repeat (50) step(1'b1);
        drain();
        stop_run();

        // Near one chip per sample: several wraps
        start_run(32'hFFFF_FFFF, 4'd6, 4'd1, 1'b1);
        repeat (4200) step(1'b1);
        drain();
        stop_run();

        // Random runs; config pins scrambled outside LOAD must be ignored
        for (int r = 0; r < 4; r++) begin
            start_run($urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            for (int i = 0; i < 1500; i++) begin
                step(1'($urandom_range(0, 1)));
                cfg_fcw    = $urandom;
                cfg_tap1   = 4'($urandom_range(0, 15));
                cfg_tap2   = 4'($urandom_range(0, 15));
                cfg_boc_en = 1'($urandom_range(0, 1));
            end
            drain();
            stop_run();
        end

        // Reset in the middle of a run
        start_run(32'h8000_0000, 4'd1, 4'd3, 1'b0);
        repeat (300) step(1'b1);
        @(negedge rx_clk);
        #2;
        rx_rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", 32'({tx_valid, tx_prn_sop, tx_prn_eop, tx_loc_boc, tx_busy}), 32'd0);
        chk("rst_mid_chip", 32'(tx_chip_cnt), 32'd0);
        exp_q.delete();
        m_run = 1'b0;
        @(negedge rx_clk);
        rx_rst_n = 1'b1;
        repeat (20) step(1'b1);
        chk("rst_after_busy", 32'(tx_busy), 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
